// File: rtl/contador_rfwild_pkg.sv
// Shared defaults and sizing helpers for the RFWild130 heartbeat counter.
package contador_rfwild_pkg;

    localparam int CNT_WIDTH  = 4;
    localparam int CNT_MODULO = 16;
    localparam int CNT_DIV    = 1;

    // Phase register width for a divide-by-div prescaler; never narrower than one bit.
    function automatic int presc_width(input int div);
        return (div <= 1) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/contador_rfwild_presc.sv
// Clock-enable prescaler: tick_o is high on every DIV-th cycle after reset release.
// With DIV=1 the phase register is stuck at zero and tick_o collapses to a constant 1.
module contador_rfwild_presc
    import contador_rfwild_pkg::*;
#(
    parameter int DIV = CNT_DIV
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int PW = presc_width(DIV);
    localparam logic [PW-1:0] PHASE_LAST = PW'(DIV - 1);

    if (DIV < 1) begin : g_bad_div
        $error("contador_rfwild_presc: DIV must be >= 1");
    end

    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;

    always_comb begin
        phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign tick_o = (phase_q == PHASE_LAST);

endmodule

// File: rtl/contador_rfwild.sv
// Free-running modulo-MODULO up-counter advanced by a prescaler tick, with terminal-count flag.
// The count is taken straight from its register so the pads see a clean value right after reset.
module contador_rfwild
    import contador_rfwild_pkg::*;
#(
    parameter int WIDTH  = CNT_WIDTH,
    parameter int MODULO = CNT_MODULO,
    parameter int DIV    = CNT_DIV
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] contador,
    output logic             tc
);

    if (WIDTH < 1 || MODULO < 2 || longint'(MODULO) > (longint'(1) << WIDTH)) begin : g_bad_modulo
        $error("contador_rfwild: need WIDTH >= 1 and 2 <= MODULO <= 2**WIDTH");
    end

    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(MODULO - 1);

    logic             tick;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    contador_rfwild_presc #(
        .DIV (DIV)
    ) u_presc (
        .clk_i  (clk),
        .rst_i  (reset),
        .tick_o (tick)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (tick) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign contador = cnt_q;
    // Reset gating keeps tc low immediately on an asynchronous reset, before any edge.
    assign tc       = (cnt_q == CNT_LAST) && tick && !reset;

endmodule

// File: tb/tb_contador_rfwild.sv
`timescale 1ns/1ps
module tb_contador_rfwild;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] c0, c1, c2;
    logic       t0, t1, t2;

    int compared   = 0;
    int mismatched = 0;
    int unsigned n = 0;   // counted clock edges since the last reset release

    always #10 clk = ~clk;

    contador_rfwild u_def (
        .clk(clk), .reset(reset), .contador(c0), .tc(t0)
    );
    contador_rfwild #(.MODULO(10)) u_mod10 (
        .clk(clk), .reset(reset), .contador(c1), .tc(t1)
    );
    contador_rfwild #(.DIV(3)) u_div3 (
        .clk(clk), .reset(reset), .contador(c2), .tc(t2)
    );

    // Reference model: after n enabled edges the count is floor(n/DIV) mod MODULO.
    function automatic int mod_of(input int i);
        return (i == 1) ? 10 : 16;
    endfunction

    function automatic int div_of(input int i);
        return (i == 2) ? 3 : 1;
    endfunction

    function automatic logic [3:0] exp_cnt(input int i);
        return 4'((n / div_of(i)) % mod_of(i));
    endfunction

    function automatic logic exp_tc(input int i);
        return !reset && ((n % div_of(i)) == div_of(i) - 1)
               && (((n / div_of(i)) % mod_of(i)) == mod_of(i) - 1);
    endfunction

    function automatic logic [3:0] act_cnt(input int i);
        return (i == 0) ? c0 : (i == 1) ? c1 : c2;
    endfunction

    function automatic logic act_tc(input int i);
        return (i == 0) ? t0 : (i == 1) ? t1 : t2;
    endfunction

    task automatic step();
        @(posedge clk);
        if (!reset) n++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        n = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (act_cnt(i) !== 4'd0 || act_tc(i) !== 1'b0) begin
                mismatched++;
                $display("FAIL reset inst%0d: contador=%0d tc=%b, expected contador=0 tc=0",
                         i, act_cnt(i), act_tc(i));
            end
        end
    endtask

    task automatic test_count();
        reset = 1'b0;
        for (int e = 0; e < 20; e++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                compared++;
                if (act_cnt(i) !== exp_cnt(i) || act_tc(i) !== exp_tc(i)) begin
                    mismatched++;
                    $display("FAIL count inst%0d edge%0d: contador=%0d tc=%b, expected contador=%0d tc=%b",
                             i, e, act_cnt(i), act_tc(i), exp_cnt(i), exp_tc(i));
                end
            end
        end
    endtask

    task automatic test_async_pulse();
        int budget = 64;
        while (exp_cnt(0) != 4'd4 && budget > 0) begin
            step();
            budget--;
        end
        compared++;
        if (c0 !== 4'd4) begin
            mismatched++;
            $display("FAIL pulse_setup: contador=%0d, expected 4 (budget left %0d)", c0, budget);
        end
        #3 reset = 1'b1;
        n = 0;
        #1;
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (act_cnt(i) !== 4'd0 || act_tc(i) !== 1'b0) begin
                mismatched++;
                $display("FAIL pulse_async inst%0d: contador=%0d tc=%b, expected contador=0 tc=0",
                         i, act_cnt(i), act_tc(i));
            end
        end
        #4 reset = 1'b0;
        for (int e = 0; e < 4; e++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                compared++;
                if (act_cnt(i) !== exp_cnt(i) || act_tc(i) !== exp_tc(i)) begin
                    mismatched++;
                    $display("FAIL pulse_restart inst%0d edge%0d: contador=%0d tc=%b, expected contador=%0d tc=%b",
                             i, e, act_cnt(i), act_tc(i), exp_cnt(i), exp_tc(i));
                end
            end
        end
    endtask

    task automatic test_reset_held();
        reset = 1'b1;
        n = 0;
        for (int e = 0; e < 10; e++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                compared++;
                if (act_cnt(i) !== 4'd0 || act_tc(i) !== 1'b0) begin
                    mismatched++;
                    $display("FAIL reset_held inst%0d edge%0d: contador=%0d tc=%b, expected contador=0 tc=0",
                             i, e, act_cnt(i), act_tc(i));
                end
            end
        end
    endtask

    task automatic test_edge_release();
        reset = 1'b1;
        n = 0;
        step();
        // Release lands in the same time step as the edge; the flops sample reset still high.
        @(posedge clk);
        reset <= 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (act_cnt(i) !== 4'd0 || act_tc(i) !== 1'b0) begin
                mismatched++;
                $display("FAIL edge_release_hold inst%0d: contador=%0d tc=%b, expected contador=0 tc=0",
                         i, act_cnt(i), act_tc(i));
            end
        end
        for (int e = 0; e < 6; e++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                compared++;
                if (act_cnt(i) !== exp_cnt(i) || act_tc(i) !== exp_tc(i)) begin
                    mismatched++;
                    $display("FAIL edge_release inst%0d edge%0d: contador=%0d tc=%b, expected contador=%0d tc=%b",
                             i, e, act_cnt(i), act_tc(i), exp_cnt(i), exp_tc(i));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                #($urandom_range(1, 4)) reset = 1'b1;
                n = 0;
                #1;
                for (int i = 0; i < 3; i++) begin
                    compared++;
                    if (act_cnt(i) !== 4'd0 || act_tc(i) !== 1'b0) begin
                        mismatched++;
                        $display("FAIL random_pulse inst%0d iter%0d: contador=%0d tc=%b, expected contador=0 tc=0",
                                 i, k, act_cnt(i), act_tc(i));
                    end
                end
                #($urandom_range(1, 3)) reset = 1'b0;
            end
            step();
            for (int i = 0; i < 3; i++) begin
                compared++;
                if (act_cnt(i) !== exp_cnt(i) || act_tc(i) !== exp_tc(i)) begin
                    mismatched++;
                    $display("FAIL random inst%0d iter%0d n=%0d: contador=%0d tc=%b, expected contador=%0d tc=%b",
                             i, k, n, act_cnt(i), act_tc(i), exp_cnt(i), exp_tc(i));
                end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_count();
        test_async_pulse();
        test_reset_held();
        test_edge_release();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
